writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback stage plus integer register file; sits downstream of the MEM/WB stage register and upstream of the decode stage. Selects the writeback value (memory load data or ALU result) from the MEM/WB control bits, commits it to a 32-entry register file on the rising clock edge, and serves two combinational read ports to decode. Same-cycle write-to-read bypass means decode never sees a stale value for the register being written back.

## Interface
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width; depth is 2**ADDR_W
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clk
- regwrite_in  in  1  writeback enable, from MEM/WB
- memtoreg_in  in  1  1 = write mem_read_data_in, 0 = write alu_result_in
- mem_read_data_in  in  DATA_W  load data from MEM/WB
- alu_result_in  in  DATA_W  ALU result / address from MEM/WB
- rd_in  in  ADDR_W  destination register from MEM/WB
- rs1_addr, rs2_addr  in  ADDR_W  decode read addresses
- rs1_data, rs2_data  out  DATA_W  read data, combinational, bypassed
- wb_data_out  out  DATA_W  selected writeback value, combinational, for forwarding
- wb_en_out  out  1  effective write: regwrite_in && rd_in != 0
- wb_count_out  out  32  count of committed register writes, wraps

## Operation
- wb_data_out = memtoreg_in ? mem_read_data_in : alu_result_in; a pure function of inputs, independent of regwrite_in.
- wb_en_out = regwrite_in && (rd_in != 0).
- Commit: on a rising edge with wb_en_out = 1, regs[rd_in] <= wb_data_out.
- Register 0 is hardwired zero. Writes to it are dropped, reads return 0, and it is never bypassed.
- Read port n:
  - addr == 0 gives 0.
  - Otherwise, wb_en_out && addr == rd_in gives wb_data_out (bypass).
  - Otherwise gives regs[addr].
- Both ports may read the same address, including the one being written; both return identical values.
- wb_count_out increments by 1 on each edge where wb_en_out = 1. It wraps from 0xFFFF_FFFF to 0.
- Reset (asynchronous, dominates clk): all regs[1..31] <= 0 and wb_count_out <= 0. While reset is high, no write commits and reads return 0 for every address.
- Reset asserted mid-operation: any pending write at that edge is lost. The first commit occurs on the first rising edge after reset deasserts.

## Timing
- Write latency: 1 edge. Bypass makes the value visible on the read ports in the same cycle it is presented, and it stays visible from the array on every later cycle.
- Read path is combinational (no latency). Output changes follow rs*_addr, rd_in, the data inputs and the control inputs within the cycle.
- Reset values:
  - rs1_data = rs2_data = 0 (array cleared).
  - wb_count_out = 0.
  - wb_data_out and wb_en_out follow the inputs; they have no state.
- Simultaneous events:
  - Write and read of the same register in one cycle returns the new value.
  - Back-to-back writes to the same register: the later one wins.
  - regwrite_in = 1 with rd_in = 0: no write, no count increment, wb_en_out = 0.

## Structure
- Shared package `cpu_pkg`: DATA_W/ADDR_W constants, the REG_ZERO index constant, and the writeback source-select encoding (WB_SRC_ALU = 0, WB_SRC_MEM = 1).
- One natural sub-module, `regfile_2r1w`: 2-read/1-write array with async clear and x0 hardwiring.
- The top level holds the writeback mux, the bypass comparators and the write counter.

## Test plan
- Reset, then read all 32 addresses on both ports -> all 0; wb_count_out = 0.
- regwrite=1, memtoreg=0, alu=0x0000_1234, rd=5, rs1=5 in the same cycle -> rs1_data = 0x1234 before the edge (bypass); after the edge, with regwrite=0, rs1_data = 0x1234 and wb_count_out = 1.
- regwrite=1, memtoreg=1, mem=0xDEAD_BEEF, alu=0x1, rd=7 -> wb_data_out = 0xDEADBEEF; after the edge, rs2=7 reads 0xDEADBEEF.
- regwrite=1, rd=0, alu=0xFFFF_FFFF, rs1=rs2=0 -> reads 0 before and after the edge; wb_en_out = 0; count unchanged.
- Write 0xA to r3, then write 0xB to r3 on consecutive edges -> r3 reads 0xB. Then assert reset mid-cycle between edges -> r3 reads 0 immediately and wb_count_out = 0.
- Preload wb_count_out to 0xFFFF_FFFF via a forced/long write sequence, then perform one commit -> wb_count_out = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and encodings used by the writeback stage and register file.
// Contents: datapath/index widths, the hardwired-zero register index, and the
// writeback source-select encoding carried in the MEM/WB memtoreg bit.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write integer register array, asynchronously cleared, x0 hardwired to zero.
// Ports: clk/reset (async, active-high); we/waddr/wdata commit on the rising edge;
//        raddr1/raddr2 -> rdata1/rdata2 read the stored array combinationally (no bypass here).
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int DEPTH = 1 << AW;

  // Entry 0 has no storage at all; reads of it fall through to zero below.
  logic [DW-1:0] regs [1:DEPTH-1];

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (we && (waddr == AW'(i))) begin
        regs[i] <= wdata;
      end
    end
  end

  // Decoded read muxes: any address without a storage entry (only x0) reads zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int j = 1; j < DEPTH; j++) begin
      if (raddr1 == AW'(j)) rdata1 = regs[j];
      if (raddr2 == AW'(j)) rdata2 = regs[j];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus 32-entry register file with two bypassed combinational read ports.
// Ports: clk/reset (async, active-high); MEM/WB inputs regwrite_in, memtoreg_in,
//        mem_read_data_in, alu_result_in, rd_in; decode reads rs1/rs2_addr -> rs1/rs2_data;
//        wb_data_out/wb_en_out for forwarding; wb_count_out counts committed writes (wraps).
module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [DATA_W-1:0] mem_read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              wb_en_out,
  output logic [31:0]       wb_count_out
);

  wb_src_e           wb_src;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              byp1;
  logic              byp2;
  logic [31:0]       wb_count_q;

  assign wb_src      = wb_src_e'(memtoreg_in);
  assign wb_data_out = (wb_src == WB_SRC_MEM) ? mem_read_data_in : alu_result_in;
  assign wb_en_out   = regwrite_in && (rd_in != ADDR_W'(REG_ZERO));

  regfile_2r1w #(
    .DW(DATA_W),
    .AW(ADDR_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en_out),
    .waddr  (rd_in),
    .wdata  (wb_data_out),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // wb_en_out already excludes rd_in == 0, so x0 can never be bypassed. The bypass is
  // suppressed during reset so every read is zero while the array is held cleared.
  assign byp1 = !reset && wb_en_out && (rs1_addr == rd_in);
  assign byp2 = !reset && wb_en_out && (rs2_addr == rd_in);

  assign rs1_data = byp1 ? wb_data_out : rf_rdata1;
  assign rs2_data = byp2 ? wb_data_out : rf_rdata2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_count_q <= '0;
    end else if (wb_en_out) begin
      wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign wb_count_out = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        regwrite_in;
  logic        memtoreg_in;
  logic [31:0] mem_read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  rd_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data_out;
  logic        wb_en_out;
  logic [31:0] wb_count_out;

  int total = 0;
  int bad   = 0;

  writeback_regfile dut (
    .clk              (clk),
    .reset            (reset),
    .regwrite_in      (regwrite_in),
    .memtoreg_in      (memtoreg_in),
    .mem_read_data_in (mem_read_data_in),
    .alu_result_in    (alu_result_in),
    .rd_in            (rd_in),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_data_out      (wb_data_out),
    .wb_en_out        (wb_en_out),
    .wb_count_out     (wb_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  int          preload_seq  = 0;
  int          preload_seen = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_count = 32'd0;
    end else begin
      if (preload_seq != preload_seen) begin
        m_count      = 32'hFFFF_FFFF;
        preload_seen = preload_seq;
      end
      if (regwrite_in && rd_in != 5'd0) begin
        m_regs[rd_in] = memtoreg_in ? mem_read_data_in : alu_result_in;
        m_count       = m_count + 32'd1;
      end
    end
  end

  function automatic logic [31:0] exp_wb();
    return memtoreg_in ? mem_read_data_in : alu_result_in;
  endfunction

  function automatic logic exp_en();
    return regwrite_in && (rd_in != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    if (exp_en() && a == rd_in) return exp_wb();
    return m_regs[a];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the falling edge and compare every output against the model.
  task automatic sample();
    @(negedge clk);
    check("rs1_data", rs1_data, exp_rd(rs1_addr));
    check("rs2_data", rs2_data, exp_rd(rs2_addr));
    check("wb_data_out", wb_data_out, exp_wb());
    check("wb_en_out", {31'd0, wb_en_out}, {31'd0, exp_en()});
    check("wb_count_out", wb_count_out, m_count);
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2);
    regwrite_in      = rw;
    memtoreg_in      = m2r;
    mem_read_data_in = mem;
    alu_result_in    = alu;
    rd_in            = rd;
    rs1_addr         = a1;
    rs2_addr         = a2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    next();
    next();
    // While reset is high even a matching write must not be visible.
    drive(1'b1, 1'b0, 32'd0, 32'h5555_5555, 5'd9, 5'd9, 5'd9);
    sample();
    check("rst_read", rs1_data, 32'd0);
    check("rst_en_follows", {31'd0, wb_en_out}, 32'd1);
    next();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

    // All addresses read zero after reset.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i));
      sample();
      next();
    end
    check("count_after_rst", wb_count_out, 32'd0);

    // ALU writeback to r5 with same-cycle bypass.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
    sample();
    check("bypass_r5", rs1_data, 32'h0000_1234);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    sample();
    check("r5_stored", rs1_data, 32'h0000_1234);
    check("count_1", wb_count_out, 32'd1);
    next();

    // Memory writeback to r7.
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd0, 5'd7);
    sample();
    check("wb_mem_sel", wb_data_out, 32'hDEAD_BEEF);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
    sample();
    check("r7_stored", rs2_data, 32'hDEAD_BEEF);
    next();

    // Write to x0 is dropped.
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    sample();
    check("x0_en", {31'd0, wb_en_out}, 32'd0);
    check("x0_byp", rs1_data, 32'd0);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    sample();
    check("x0_after", rs2_data, 32'd0);
    check("count_x0", wb_count_out, 32'd2);
    next();

    // regwrite=0 still shows the mux value but does not commit.
    drive(1'b0, 1'b0, 32'h0, 32'hCAFE_0001, 5'd9, 5'd9, 5'd9);
    sample();
    check("no_rw_byp", rs1_data, 32'd0);
    next();

    // Back-to-back writes to r3, later wins; read both ports of the written reg.
    drive(1'b1, 1'b0, 32'h0, 32'hA, 5'd3, 5'd3, 5'd3);
    sample();
    next();
    drive(1'b1, 1'b1, 32'hB, 32'h0, 5'd3, 5'd3, 5'd3);
    sample();
    check("r3_byp_both", rs2_data, 32'hB);
    next();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0777, 5'd4, 5'd3, 5'd4);
    sample();
    check("r3_later_wins", rs1_data, 32'hB);
    next();

    // Reset mid-cycle with a write to r4 pending: lost; clears r3.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0999, 5'd4, 5'd3, 5'd4);
    #1 reset = 1'b1;
    sample();
    check("r3_rst", rs1_data, 32'd0);
    check("count_rst", wb_count_out, 32'd0);
    next();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0888, 5'd4, 5'd4, 5'd3);
    sample();
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);
    sample();
    check("first_commit", rs1_data, 32'h0000_0888);
    check("count_post_rst", wb_count_out, 32'd1);
    next();

    // Counter wrap: preload to all-ones, then one commit.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd31, 5'd31, 5'd1);
    sample();
    #1;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    release dut.wb_count_q;
    preload_seq++;
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd1);
    sample();
    check("count_wrap", wb_count_out, 32'd0);
    check("r31_stored", rs1_data, 32'h0000_00AA);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
